// File: rtl/axis_pkt_gen.sv
`default_nettype none
// ============================================================================
//  Module      : axis_pkt_gen
//  Description : AXI4-Stream packet generator. Emits a programmed number of
//                packets of a programmed byte length with an index or LFSR
//                data pattern, a correct final-beat tkeep and a configurable
//                inter-packet gap. Honours tready backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_pkt_gen #(
    parameter int TDATA_WIDTH = 64,
    parameter int TDATA_BYTES = 8
) (
    input  logic                   s_axis_aclk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [15:0]            pkt_bytes,
    input  logic [7:0]             num_pkts,
    input  logic                   pattern_sel,
    input  logic [7:0]             gap_cycles,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [TDATA_BYTES-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            pkts_sent
);

    localparam int          LOG2_BYTES = $clog2(TDATA_BYTES);
    localparam int          HALF_WIDTH = TDATA_WIDTH / 2;
    localparam logic [31:0] LFSR_SEED  = 32'hACE1_0001;
    localparam logic [31:0] LFSR_MASK  = 32'h8020_0003;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t                   state_q;
    logic [15:0]              last_beat_q;   // index of the final beat (B-1)
    logic [TDATA_BYTES-1:0]   last_keep_q;   // tkeep of the final beat
    logic [7:0]               num_q;
    logic                     pat_q;
    logic [7:0]               gap_q;
    logic [15:0]              beat_q;
    logic [7:0]               pkt_q;
    logic [7:0]               gap_cnt_q;
    logic [31:0]              lfsr_q;
    logic [15:0]              pkts_sent_q;
    logic [TDATA_WIDTH-1:0]   tdata_q;
    logic [TDATA_BYTES-1:0]   tkeep_q;
    logic                     tlast_q;
    logic                     tvalid_q;
    logic                     busy_q;
    logic                     done_q;

    logic                     handshake;
    logic [LOG2_BYTES-1:0]    rem;
    logic [15:0]              last_beat_d;
    logic [TDATA_BYTES-1:0]   last_keep_d;
    logic                     pat_d;
    logic [15:0]              beat_d;
    logic [7:0]               pkt_d;
    logic [31:0]              lfsr_d;
    logic [TDATA_WIDTH-1:0]   tdata_d;
    logic [TDATA_BYTES-1:0]   tkeep_d;
    logic                     tlast_d;

    // Next beat contents: whatever beat would be presented after this edge.
    // In IDLE the live config inputs are used so the first beat can load on
    // the same edge that latches the config.
    always_comb begin
        handshake   = tvalid_q && m_axis_tready;
        rem         = pkt_bytes[LOG2_BYTES-1:0];
        last_beat_d = last_beat_q;
        last_keep_d = last_keep_q;
        pat_d       = pat_q;
        if (state_q == ST_IDLE) begin
            // floor((bytes-1)/N) == ceil(bytes/N)-1 without a 17-bit sum
            last_beat_d = (pkt_bytes - 16'd1) >> LOG2_BYTES;
            pat_d       = pattern_sel;
            for (int i = 0; i < TDATA_BYTES; i++) begin
                last_keep_d[i] = (rem == '0) || (LOG2_BYTES'(i) < rem);
            end
        end

        beat_d = 16'd0;
        if (state_q == ST_SEND && handshake && !tlast_q) begin
            beat_d = beat_q + 16'd1;
        end

        pkt_d = pkt_q;
        if (state_q == ST_IDLE) begin
            pkt_d = 8'd0;
        end else if (state_q == ST_SEND && handshake && tlast_q) begin
            pkt_d = pkt_q + 8'd1;
        end

        // Galois step only on a completed beat
        lfsr_d = lfsr_q;
        if (state_q == ST_SEND && handshake) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 32'd0);
        end

        tlast_d = (beat_d == last_beat_d);
        tkeep_d = tlast_d ? last_keep_d : '1;
        if (pat_d) begin
            tdata_d = {(TDATA_WIDTH/32){lfsr_d}};
        end else begin
            tdata_d = {HALF_WIDTH'(pkt_d), HALF_WIDTH'(beat_d)};
        end
        for (int i = 0; i < TDATA_BYTES; i++) begin
            if (!tkeep_d[i]) begin
                tdata_d[8*i +: 8] = 8'h00;
            end
        end
    end

    // Run sequencer with registered stream and status outputs.
    always_ff @(posedge s_axis_aclk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_beat_q <= 16'd0;
            last_keep_q <= '0;
            num_q       <= 8'd0;
            pat_q       <= 1'b0;
            gap_q       <= 8'd0;
            beat_q      <= 16'd0;
            pkt_q       <= 8'd0;
            gap_cnt_q   <= 8'd0;
            lfsr_q      <= LFSR_SEED;
            pkts_sent_q <= 16'd0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tlast_q     <= 1'b0;
            tvalid_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        last_beat_q <= last_beat_d;
                        last_keep_q <= last_keep_d;
                        num_q       <= num_pkts;
                        pat_q       <= pattern_sel;
                        gap_q       <= gap_cycles;
                        if (pkt_bytes == 16'd0 || num_pkts == 8'd0) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= ST_SEND;
                            busy_q   <= 1'b1;
                            pkt_q    <= pkt_d;
                            beat_q   <= beat_d;
                            tdata_q  <= tdata_d;
                            tkeep_q  <= tkeep_d;
                            tlast_q  <= tlast_d;
                            tvalid_q <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (handshake) begin
                        lfsr_q <= lfsr_d;
                        if (tlast_q) begin
                            pkts_sent_q <= pkts_sent_q + 16'd1;
                            pkt_q       <= pkt_d;
                            if (pkt_q == num_q - 8'd1) begin
                                state_q  <= ST_FIN;
                                busy_q   <= 1'b0;
                                done_q   <= 1'b1;
                                tvalid_q <= 1'b0;
                                tlast_q  <= 1'b0;
                                tkeep_q  <= '0;
                                tdata_q  <= '0;
                            end else if (gap_q == 8'd0) begin
                                // back-to-back packets: tvalid stays high
                                beat_q  <= beat_d;
                                tdata_q <= tdata_d;
                                tkeep_q <= tkeep_d;
                                tlast_q <= tlast_d;
                            end else begin
                                state_q   <= ST_GAP;
                                gap_cnt_q <= gap_q;
                                tvalid_q  <= 1'b0;
                                tlast_q   <= 1'b0;
                                tkeep_q   <= '0;
                                tdata_q   <= '0;
                            end
                        end else begin
                            beat_q  <= beat_d;
                            tdata_q <= tdata_d;
                            tkeep_q <= tkeep_d;
                            tlast_q <= tlast_d;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == 8'd1) begin
                        state_q  <= ST_SEND;
                        beat_q   <= beat_d;
                        tdata_q  <= tdata_d;
                        tkeep_q  <= tkeep_d;
                        tlast_q  <= tlast_d;
                        tvalid_q <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                    end
                end
                ST_FIN: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pkts_sent     = pkts_sent_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_pkt_gen
//  Description : Self-checking bench for axis_pkt_gen. Expected beats are
//                built per run from packet length, count and pattern rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_pkt_gen;

    localparam int          W    = 64;
    localparam int          NB   = 8;
    localparam logic [31:0] SEED = 32'hACE1_0001;

    logic          s_axis_aclk = 1'b0;
    logic          rst;
    logic          start;
    logic [15:0]   pkt_bytes;
    logic [7:0]    num_pkts;
    logic          pattern_sel;
    logic [7:0]    gap_cycles;
    logic [W-1:0]  tdata;
    logic [NB-1:0] tkeep;
    logic          tlast;
    logic          tvalid;
    logic          tready;
    logic          busy;
    logic          done;
    logic [15:0]   pkts_sent;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [31:0]   m_lfsr   = SEED;
    logic [15:0]   m_pkts   = 16'd0;

    axis_pkt_gen #(
        .TDATA_WIDTH (W),
        .TDATA_BYTES (NB)
    ) dut (
        .s_axis_aclk   (s_axis_aclk),
        .rst           (rst),
        .start         (start),
        .pkt_bytes     (pkt_bytes),
        .num_pkts      (num_pkts),
        .pattern_sel   (pattern_sel),
        .gap_cycles    (gap_cycles),
        .m_axis_tdata  (tdata),
        .m_axis_tkeep  (tkeep),
        .m_axis_tlast  (tlast),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .busy          (busy),
        .done          (done),
        .pkts_sent     (pkts_sent)
    );

    always #5 s_axis_aclk = ~s_axis_aclk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0000_0000);
    endfunction

    // One run: build the expected beat list, launch, then watch every cycle.
    task automatic run_case(input int bytes, input int npkts, input bit pat,
                            input int gap, input bit rnd_ready);
        logic [W-1:0]  q_data[$];
        logic [NB-1:0] q_keep[$];
        bit            q_last[$];
        logic [31:0]   s;
        logic [W-1:0]  d;
        logic [NB-1:0] k;
        int            nb, total, hs, pkts_seen, cyc, gap_len, budget;
        bit            zero_run, in_gap, expect_done, done_seen, first;

        zero_run = (bytes == 0) || (npkts == 0);
        nb       = zero_run ? 0 : (bytes + NB - 1) / NB;
        total    = zero_run ? 0 : nb * npkts;
        s        = m_lfsr;
        for (int p = 0; p < (zero_run ? 0 : npkts); p++) begin
            for (int b = 0; b < nb; b++) begin
                k = '1;
                if (b == nb - 1 && (bytes % NB) != 0) k = NB'((1 << (bytes % NB)) - 1);
                if (pat) d = {(W/32){s}};
                else     d = (W'(p) << (W/2)) | W'(b);
                for (int i = 0; i < NB; i++) if (!k[i]) d[8*i +: 8] = 8'h00;
                q_data.push_back(d);
                q_keep.push_back(k);
                q_last.push_back(b == nb - 1);
                s = lfsr_next(s);
            end
        end
        if (!zero_run) m_pkts = m_pkts + 16'(npkts);

        @(negedge s_axis_aclk);
        pkt_bytes   = bytes[15:0];
        num_pkts    = npkts[7:0];
        pattern_sel = pat;
        gap_cycles  = gap[7:0];
        start       = 1'b1;
        @(negedge s_axis_aclk);

        budget      = total * 20 + npkts * (gap + 2) + 20;
        hs          = 0;
        pkts_seen   = 0;
        cyc         = 0;
        gap_len     = 0;
        in_gap      = 1'b0;
        expect_done = zero_run;
        done_seen   = 1'b0;
        first       = 1'b1;
        while (!done_seen) begin
            if (cyc > budget) begin
                check("timeout", cyc, budget);
                break;
            end
            if (expect_done) begin
                check("done_pulse", done, 1);
                check("busy_at_done", busy, 0);
                check("tvalid_at_done", tvalid, 0);
                done_seen = 1'b1;
            end else begin
                check("done_low", done, 0);
                check("busy_high", busy, 1);
                if (first) check("first_tvalid", tvalid, 1);
                if (in_gap) begin
                    if (tvalid) begin
                        check("gap_len", gap_len, gap);
                        in_gap = 1'b0;
                    end else begin
                        gap_len++;
                    end
                end
                tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (tvalid) begin
                    if (q_data.size() == 0) begin
                        check("extra_beat", hs + 1, total);
                    end else begin
                        check("tdata", tdata, q_data[0]);
                        check("tkeep", tkeep, q_keep[0]);
                        check("tlast", tlast, q_last[0]);
                        if (tready) begin
                            hs++;
                            if (q_last[0]) begin
                                pkts_seen++;
                                if (pkts_seen == npkts) expect_done = 1'b1;
                                else begin
                                    in_gap  = 1'b1;
                                    gap_len = 0;
                                end
                            end
                            void'(q_data.pop_front());
                            void'(q_keep.pop_front());
                            void'(q_last.pop_front());
                        end
                    end
                end
            end
            first = 1'b0;
            // junk on the config/start inputs while busy must be ignored
            start       = busy && ($urandom_range(0, 3) == 0);
            pkt_bytes   = 16'($urandom);
            num_pkts    = 8'($urandom);
            pattern_sel = 1'($urandom);
            gap_cycles  = 8'($urandom);
            if (!done_seen) begin
                @(negedge s_axis_aclk);
                cyc++;
            end
        end
        start  = 1'b0;
        tready = 1'b1;
        check("handshakes", hs, total);
        check("pkts_sent", pkts_sent, m_pkts);
        m_lfsr = s;
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        pkt_bytes   = 16'd0;
        num_pkts    = 8'd0;
        pattern_sel = 1'b0;
        gap_cycles  = 8'd0;
        tready      = 1'b1;
        repeat (3) @(negedge s_axis_aclk);
        check("rst_tvalid", tvalid, 0);
        check("rst_tdata", tdata, 0);
        check("rst_tkeep", tkeep, 0);
        check("rst_tlast", tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pkts_sent", pkts_sent, 0);
        rst = 1'b0;

        run_case(16, 1, 1'b0, 0, 1'b0);
        run_case(13, 2, 1'b0, 3, 1'b0);
        run_case(13, 2, 1'b0, 3, 1'b1);
        run_case(8, 3, 1'b1, 0, 1'b0);
        run_case(0, 5, 1'b0, 0, 1'b0);
        run_case(24, 0, 1'b1, 1, 1'b0);
        for (int r = 0; r < 8; r++) begin
            run_case($urandom_range(1, 70), $urandom_range(1, 4), 1'($urandom),
                     $urandom_range(0, 3), 1'($urandom));
        end
        run_case(65535, 1, 1'b0, 0, 1'b0);

        // reset while a beat is stalled on the bus
        @(negedge s_axis_aclk);
        pkt_bytes   = 16'd64;
        num_pkts    = 8'd2;
        pattern_sel = 1'b1;
        gap_cycles  = 8'd0;
        tready      = 1'b0;
        start       = 1'b1;
        @(negedge s_axis_aclk);
        start = 1'b0;
        check("stall_tvalid", tvalid, 1);
        repeat (3) @(negedge s_axis_aclk);
        rst = 1'b1;
        @(negedge s_axis_aclk);
        check("midrst_tvalid", tvalid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_pkts_sent", pkts_sent, 0);
        check("midrst_tdata", tdata, 0);
        rst    = 1'b0;
        tready = 1'b1;
        m_lfsr = SEED;
        m_pkts = 16'd0;
        run_case(8, 2, 1'b1, 1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_pkt_gen.md
Name: axis_pkt_gen

Overview:
- AXI4-Stream packet transmitter that emulates the DMA MM2S side, sourcing framed packets into the stream processing blocks.
- Generates a programmed number of packets of a programmed byte length, with deterministic data patterns, correct tkeep on the final beat, and a configurable inter-packet gap.
- Fully honours tready backpressure.
- Used for on-board bring-up and as bench stimulus for downstream stream blocks.

Parameters:
- TDATA_WIDTH, 64, stream data width in bits; must be 32, 64 or 128.
- TDATA_BYTES, 8, byte lanes; must equal TDATA_WIDTH/8.

Ports:
- s_axis_aclk  in  1  clock for all logic.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin a run; sampled only in IDLE.
- pkt_bytes  in  16  bytes per packet; latched on start.
- num_pkts  in  8  packets per run; latched on start.
- pattern_sel  in  1  0 = index pattern, 1 = LFSR pattern; latched on start.
- gap_cycles  in  8  idle cycles (tvalid low) between packets; latched on start.
- m_axis_tdata  out  TDATA_WIDTH  stream data.
- m_axis_tkeep  out  TDATA_BYTES  byte enables.
- m_axis_tlast  out  1  last beat of packet.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  sink ready.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at end of run.
- pkts_sent  out  16  packets completed since reset; wraps.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; LFSR = 32'hACE1_0001; counters cleared. rst has priority over every other event, including mid-packet. tvalid is 0 at the edge after rst, and no beat is completed on that edge.
- FSM states: IDLE, SEND, GAP, FIN.
- IDLE: on start, latch config. If pkt_bytes==0 or num_pkts==0, go to FIN (no beats). Otherwise go to SEND with pkt_idx=0, beat_idx=0.
- Latency: start sampled at edge N; tvalid=1 with the first beat from edge N+1.
- Beats per packet: B = ceil(pkt_bytes/TDATA_BYTES).
- Handshake: a beat completes only when tvalid&&tready. While tvalid=1 and tready=0, tdata, tkeep and tlast hold stable. tvalid never drops without a handshake (no retraction).
- tkeep: all ones except on the last beat, which has the low (pkt_bytes mod TDATA_BYTES) bits set, or all ones if the remainder is 0. tkeep is always contiguous and low-aligned. Byte lanes with tkeep=0 drive 8'h00.
- tlast: 1 only when beat_idx==B-1.
- Pattern 0: low half of tdata = beat_idx zero-extended to TDATA_WIDTH/2; high half = pkt_idx zero-extended.
- Pattern 1: tdata = 32-bit LFSR value replicated across the width. LFSR is Galois, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003). It advances only on a completed beat and is not re-seeded between packets or runs (only by reset).
- On tlast handshake: pkts_sent++ and pkt_idx++.
  - If pkt_idx+1==num_pkts: go to FIN.
  - Else if gap_cycles==0: stay in SEND; next packet's first beat is presented the following cycle (tvalid may stay high continuously).
  - Else: go to GAP.
- GAP: tvalid=0 for exactly gap_cycles cycles, then SEND with beat_idx=0.
- FIN: tvalid=0; done=1 for one cycle; busy=0 on the same edge; return to IDLE.
- start while busy is ignored. Config input changes while busy have no effect.
- beat_idx counter width is 16 bits; pkt_bytes=65535 with TDATA_BYTES=8 gives B=8192.
- busy=1 in SEND and GAP; busy=0 in IDLE and FIN.

Test Plan:
- pkt_bytes=16, num_pkts=1, pattern 0, tready=1 -> 2 beats: tdata 0x0000_0000_0000_0000 then 0x0000_0000_0000_0001; tkeep 0xFF both; tlast on beat 2; done pulse the next cycle; pkts_sent=1.
- pkt_bytes=13, num_pkts=2, gap=3, tready=1 -> each packet 2 beats, last-beat tkeep=0x1F with bytes 5..7 zero; exactly 3 cycles tvalid=0 between packets; second packet tdata high half = 1.
- Same run with tready toggled by a random 50% pattern -> no beat lost or duplicated; tdata, tkeep and tlast stable whenever tvalid&&!tready; total handshakes=4.
- pkt_bytes=8, num_pkts=3, gap=0, pattern 1 -> tvalid high for 3 consecutive cycles; tdata = 0xACE10001ACE10001 followed by the next two LFSR states, each replicated.
- pkt_bytes=0, num_pkts=5 -> no tvalid; done one cycle after start accepted; pkts_sent unchanged.
- rst asserted mid-packet with tvalid=1, tready=0 -> next edge tvalid=0, busy=0, pkts_sent=0, LFSR re-seeded; a subsequent start runs normally.
